// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter that serialises per-core cache read/write requests onto one
// global-memory channel. Optional response watchdog is enabled by MEM_ARB_TIMEOUT_EN.
module mem_channel_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int CONSUMERS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CONSUMERS-1:0]           consumer_read_valid,
  input  logic [CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [CONSUMERS-1:0]           consumer_read_ready,
  output logic [CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [CONSUMERS-1:0]           consumer_write_valid,
  input  logic [CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [CONSUMERS-1:0]           consumer_write_ready,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_address,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic                           timeout_error
);

  localparam int PW = (CONSUMERS > 1) ? $clog2(CONSUMERS) : 1;

  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_e;

  state_e                         state_q, state_d;
  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [PW-1:0]                  grant_q, grant_d;
  logic                           memRdValid_q, memRdValid_d;
  logic [ADDR_BITS-1:0]           memRdAddr_q, memRdAddr_d;
  logic                           memWrValid_q, memWrValid_d;
  logic [ADDR_BITS-1:0]           memWrAddr_q, memWrAddr_d;
  logic [DATA_BITS-1:0]           memWrData_q, memWrData_d;
  logic [CONSUMERS-1:0]           consRdReady_q, consRdReady_d;
  logic [CONSUMERS*DATA_BITS-1:0] consRdData_q, consRdData_d;
  logic [CONSUMERS-1:0]           consWrReady_q, consWrReady_d;

  logic          found;
  logic          pickRead;
  logic [PW-1:0] pick;
  logic [PW-1:0] scanIdx;

  // base and off are both below CONSUMERS, so a single subtraction wraps correctly
  function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= CONSUMERS) s = s - CONSUMERS;
    return s[PW-1:0];
  endfunction

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           timeoutErr_q, timeoutErr_d;
  assign timeout_error = timeoutErr_q;
`else
  assign timeout_error = 1'b0;
`endif

  // Round-robin search starting at the pointer; reads win over writes on the same port
  always_comb begin
    found    = 1'b0;
    pickRead = 1'b0;
    pick     = '0;
    scanIdx  = '0;
    for (int i = 0; i < CONSUMERS; i++) begin
      scanIdx = wrapIdx(ptr_q, i);
      if (!found && (consumer_read_valid[scanIdx] || consumer_write_valid[scanIdx])) begin
        found    = 1'b1;
        pick     = scanIdx;
        pickRead = consumer_read_valid[scanIdx];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    memRdValid_d  = memRdValid_q;
    memRdAddr_d   = memRdAddr_q;
    memWrValid_d  = memWrValid_q;
    memWrAddr_d   = memWrAddr_q;
    memWrData_d   = memWrData_q;
    consRdReady_d = consRdReady_q;
    consRdData_d  = consRdData_q;
    consWrReady_d = consWrReady_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wdog_d        = wdog_q;
    timeoutErr_d  = timeoutErr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
`ifdef MEM_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
          if (pickRead) begin
            memRdValid_d = 1'b1;
            memRdAddr_d  = consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
            state_d      = READ_WAIT;
          end else begin
            memWrValid_d = 1'b1;
            memWrAddr_d  = consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
            memWrData_d  = consumer_write_data[pick*DATA_BITS +: DATA_BITS];
            state_d      = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          memRdValid_d                                   = 1'b0;
          consRdData_d[grant_q*DATA_BITS +: DATA_BITS]   = mem_read_data;
          consRdReady_d[grant_q]                         = 1'b1;
          state_d                                        = READ_RELAY;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          memRdValid_d                                   = 1'b0;
          consRdData_d[grant_q*DATA_BITS +: DATA_BITS]   = '1;
          consRdReady_d[grant_q]                         = 1'b1;
          timeoutErr_d                                   = 1'b1;
          state_d                                        = READ_RELAY;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          memWrValid_d           = 1'b0;
          consWrReady_d[grant_q] = 1'b1;
          state_d                = WRITE_RELAY;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          memWrValid_d           = 1'b0;
          consWrReady_d[grant_q] = 1'b1;
          timeoutErr_d           = 1'b1;
          state_d                = WRITE_RELAY;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      READ_RELAY: begin
        if (!consumer_read_valid[grant_q]) begin
          consRdReady_d[grant_q] = 1'b0;
          ptr_d                  = wrapIdx(grant_q, 1);
          state_d                = IDLE;
        end
      end
      WRITE_RELAY: begin
        if (!consumer_write_valid[grant_q]) begin
          consWrReady_d[grant_q] = 1'b0;
          ptr_d                  = wrapIdx(grant_q, 1);
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      memRdValid_q  <= 1'b0;
      memRdAddr_q   <= '0;
      memWrValid_q  <= 1'b0;
      memWrAddr_q   <= '0;
      memWrData_q   <= '0;
      consRdReady_q <= '0;
      consRdData_q  <= '0;
      consWrReady_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wdog_q        <= '0;
      timeoutErr_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      memRdValid_q  <= memRdValid_d;
      memRdAddr_q   <= memRdAddr_d;
      memWrValid_q  <= memWrValid_d;
      memWrAddr_q   <= memWrAddr_d;
      memWrData_q   <= memWrData_d;
      consRdReady_q <= consRdReady_d;
      consRdData_q  <= consRdData_d;
      consWrReady_q <= consWrReady_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wdog_q        <= wdog_d;
      timeoutErr_q  <= timeoutErr_d;
`endif
    end
  end

  assign mem_read_valid       = memRdValid_q;
  assign mem_read_address     = memRdAddr_q;
  assign mem_write_valid      = memWrValid_q;
  assign mem_write_address    = memWrAddr_q;
  assign mem_write_data       = memWrData_q;
  assign consumer_read_ready  = consRdReady_q;
  assign consumer_read_data   = consRdData_q;
  assign consumer_write_ready = consWrReady_q;

endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
Sits directly downstream of the per-core data caches and upstream of global data memory. Collects read/write requests from CONSUMERS cache memory ports and serialises them onto one global-memory channel with round-robin fairness. Routes each memory response back to the requesting port using a 4-phase valid/ready handshake on both sides.

Parameters:
ADDR_BITS, 8, address width on both sides
DATA_BITS, 8, data width on both sides
CONSUMERS, 4, number of upstream cache ports (>=2)
TIMEOUT_CYCLES, 255, memory response watchdog limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
consumer_read_valid  in  CONSUMERS  per-port read request
consumer_read_address  in  CONSUMERS x ADDR_BITS  read address
consumer_read_ready  out  CONSUMERS  read response valid
consumer_read_data  out  CONSUMERS x DATA_BITS  read response data
consumer_write_valid  in  CONSUMERS  per-port write request
consumer_write_address  in  CONSUMERS x ADDR_BITS  write address
consumer_write_data  in  CONSUMERS x DATA_BITS  write data
consumer_write_ready  out  CONSUMERS  write acknowledge
mem_read_valid  out  1  memory read request
mem_read_address  out  ADDR_BITS
mem_read_ready  in  1  memory read done
mem_read_data  in  DATA_BITS
mem_write_valid  out  1  memory write request
mem_write_address  out  ADDR_BITS
mem_write_data  out  DATA_BITS
mem_write_ready  in  1  memory write done
timeout_error  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async): all outputs 0, grant pointer 0, state IDLE, watchdog 0.
- Consumer protocol: consumer holds valid + address/data stable until its ready; arbiter holds ready high until it samples valid low.
- FSM: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE: search ports ptr, ptr+1, ... ptr+CONSUMERS-1 (mod CONSUMERS); first port with read_valid or write_valid wins. Port with both set: read served first; write served on a later grant.
- IDLE -> READ_WAIT at edge of grant: mem_read_valid=1, mem_read_address latched from consumer. Write: mem_write_valid=1, address/data latched -> WRITE_WAIT.
- READ_WAIT: on mem_read_ready=1: mem_read_valid<=0, consumer_read_data[g]<=mem_read_data, consumer_read_ready[g]<=1 -> READ_RELAY. WRITE_WAIT analogous, write_ready, no data.
- RELAY: when consumer valid[g] sampled 0: ready[g]<=0, ptr<=(g+1) mod CONSUMERS -> IDLE. Data output holds last value.
- Latency: request valid cycle 0 -> mem valid after edge 1; mem ready sampled at edge k -> consumer ready after edge k; zero-wait memory gives 2-cycle request-to-ready; next grant no earlier than 1 cycle after relay ends.
- Only one mem valid ever high; only one consumer ready ever high.
- Requests from non-granted ports ignored (no buffering); they remain pending.
- Consumer dropping valid during WAIT: memory transaction still completes; response relayed; relay ends on next edge since valid already low.
- mem_*_ready outside WAIT states ignored.
- Reset mid-transaction: everything aborts to reset values immediately.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN. With it: 8-bit-or-wider counter clears on entering a WAIT state, increments each WAIT cycle; reaching TIMEOUT_CYCLES without mem ready drops mem valid, asserts granted consumer ready (read data all ones), sets timeout_error (sticky until reset), enters RELAY. Without it: no counter, waits indefinitely, timeout_error tied 0.

Test Plan:
Single read port 0 addr 0x12, memory returns 0xAB after 3 cycles -> mem_read_address=0x12, consumer_read_data[0]=0xAB, ready[0] high until valid dropped.
Simultaneous reads on ports 0..3 after reset -> grant order 0,1,2,3; exactly one mem_read_valid at a time.
Port 2 asserts read and write (addr 0x05, data 0x7E) together -> read completes first, then write with mem_write_data=0x7E.
Port 1 serviced, then ports 0 and 1 both request -> port 2/3 search order gives port 0 next (ptr=2, wrap to 0).
Reset pulled low while in READ_WAIT -> all outputs 0 immediately; new request after release served normally.
With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, memory never responds -> after 10 wait cycles read_ready=1, data 0xFF, timeout_error=1 sticky.
